// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: configurable word width, optional parity, 1 or 2 stop bits,
// 3-sample majority vote per bit, valid/ready output with frame/parity/overrun pulses.
module uart_rx_param #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int BIT_CNT = CLK_FREQ / BAUD;
    localparam int HALF    = BIT_CNT / 2;
    localparam int CW      = $clog2(BIT_CNT + 1);
    localparam int IW      = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    state_t                state, state_next;
    logic [CW-1:0]         cnt;
    logic [IW-1:0]         idx, idx_next;
    logic                  sync1, sync2;
    logic [2:0]            samp;
    logic                  maj;
    logic [DATA_BITS-1:0]  shreg;
    logic                  frame_flag, parity_flag;
    logic                  at_half, shift_en, done;
    logic                  par_bad, frame_now, good, load;

    assign maj     = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);
    assign at_half = (cnt == CW'(HALF));
    assign busy    = (state != S_IDLE);

    // Parity bit folded into the data XOR: even wants 0, odd wants 1.
    assign par_bad   = (PARITY == 1) ? ~(^shreg ^ maj) : (^shreg ^ maj);
    // The final stop sample counts toward the frame flag in the same cycle it is taken.
    assign frame_now = frame_flag | ~maj;
    assign good      = done & ~frame_now & ~parity_flag;
    assign load      = good & (~rx_valid | rx_ready);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        state_next = state;
        idx_next   = idx;
        shift_en   = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE:  if (!sync2) state_next = S_START;
            S_START: if (at_half) state_next = maj ? S_IDLE : S_DATA;
            S_DATA: begin
                if (at_half) begin
                    shift_en = 1'b1;
                    if (idx == IW'(DATA_BITS - 1)) begin
                        idx_next   = '0;
                        state_next = (PARITY != 0) ? S_PAR : S_STOP;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            S_PAR:   if (at_half) state_next = S_STOP;
            S_STOP: begin
                if (at_half) begin
                    if (idx == IW'(STOP_BITS - 1)) begin
                        idx_next   = '0;
                        done       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        idx_next = idx + 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1       <= 1'b1;
            sync2       <= 1'b1;
            samp        <= 3'b111;
            cnt         <= '0;
            shreg       <= '0;
            frame_flag  <= 1'b0;
            parity_flag <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            sync1 <= rx;
            sync2 <= sync1;
            samp  <= {samp[1:0], sync2};
            cnt   <= (state == S_IDLE || cnt == CW'(BIT_CNT - 1)) ? '0 : cnt + 1'b1;

            if (state == S_IDLE) begin
                frame_flag  <= 1'b0;
                parity_flag <= 1'b0;
            end
            if (shift_en) shreg <= {maj, shreg[DATA_BITS-1:1]};
            if (state == S_PAR && at_half && par_bad) parity_flag <= 1'b1;
            if (state == S_STOP && at_half && !maj) frame_flag <= 1'b1;

            frame_err  <= done & frame_now;
            parity_err <= done & ~frame_now & parity_flag;
            overrun    <= good & rx_valid & ~rx_ready;

            if (load) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench for uart_rx_param: an 8N1 instance and an 8E2 instance at a scaled
// bit rate (160 clocks per bit); a negedge monitor pops expected events per instance.
module tb_uart_rx_param;

    localparam int CLK_FREQ = 16_000_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = CLK_FREQ / BAUD;

    typedef enum logic [1:0] {EV_DATA, EV_FRAME, EV_PAR, EV_OVR} ev_t;
    typedef struct packed {
        ev_t        kind;
        logic [7:0] data;
    } ev_s;

    logic       clk = 1'b0;
    logic       rst_n, rx0, rx1, rdy0, rdy1;
    logic [7:0] d0, d1;
    logic       v0, v1, fe0, fe1, pe0, pe1, ov0, ov1, b0, b1;

    ev_s q0[$];
    ev_s q1[$];
    int  total  = 0;
    int  passed = 0;
    int  v0_cycles = 0;

    always #5 clk = ~clk;

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx0), .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
        .frame_err(fe0), .parity_err(pe0), .overrun(ov0), .busy(b0)
    );

    uart_rx_param #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut_p (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
        .frame_err(fe1), .parity_err(pe1), .overrun(ov1), .busy(b1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic expect_ev(input int which, input ev_t k, input logic [7:0] d);
        ev_s e;
        e.kind = k;
        e.data = d;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    task automatic mon(input int which, input ev_t k, input logic [7:0] d);
        ev_s e;
        ev_s got;
        got.kind = k;
        got.data = d;
        if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
            total++;
            $display("FAIL unexpected_event dut%0d: got kind %0d data %0h expected none", which, k, d);
        end else begin
            e = (which == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("event_dut%0d", which), 32'(got), 32'(e));
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (v0) v0_cycles++;
            if (v0 && rdy0) mon(0, EV_DATA, d0);
            if (fe0)        mon(0, EV_FRAME, 8'h00);
            if (pe0)        mon(0, EV_PAR, 8'h00);
            if (ov0)        mon(0, EV_OVR, 8'h00);
            if (v1 && rdy1) mon(1, EV_DATA, d1);
            if (fe1)        mon(1, EV_FRAME, 8'h00);
            if (pe1)        mon(1, EV_PAR, 8'h00);
            if (ov1)        mon(1, EV_OVR, 8'h00);
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bit 0 of bits goes on the line first; each bit lasts one bit period.
    task automatic send_raw(input int which, input logic [15:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            if (which == 0) rx0 = bits[i];
            else            rx1 = bits[i];
            hold(BIT);
        end
        if (which == 0) rx0 = 1'b1;
        else            rx1 = 1'b1;
    endtask

    task automatic send_8n1(input logic [7:0] d);
        send_raw(0, {7'h00, 1'b1, d, 1'b0}, 10);
    endtask

    task automatic send_8e2(input logic [7:0] d, input logic p, input logic s1, input logic s2);
        send_raw(1, {4'h0, s2, s1, p, d, 1'b0}, 12);
    endtask

    initial begin
        int vc;
        rst_n = 1'b0;
        rx0   = 1'b1;
        rx1   = 1'b1;
        rdy0  = 1'b1;
        rdy1  = 1'b1;
        hold(4);
        check("reset_rx_data",    32'(d0), 32'h0);
        check("reset_rx_valid",   32'(v0), 32'h0);
        check("reset_frame_err",  32'(fe0), 32'h0);
        check("reset_parity_err", 32'(pe0), 32'h0);
        check("reset_overrun",    32'(ov0), 32'h0);
        check("reset_busy",       32'(b0), 32'h0);
        check("reset_busy_p",     32'(b1), 32'h0);
        rst_n = 1'b1;
        hold(BIT);

        // Single 0x55 frame, consumer always ready.
        vc = v0_cycles;
        expect_ev(0, EV_DATA, 8'h55);
        send_8n1(8'h55);
        hold(2);
        check("single_valid_cycles", 32'(v0_cycles - vc), 32'd1);
        check("single_busy_after",   32'(b0), 32'h0);

        // Sixteen back-to-back frames with no idle gap.
        for (int i = 0; i < 16; i++) expect_ev(0, EV_DATA, 8'(i));
        for (int i = 0; i < 16; i++) send_8n1(8'(i));
        hold(BIT);

        // Low stop bit; line released before a false start could be sampled low.
        expect_ev(0, EV_FRAME, 8'h00);
        expect_ev(0, EV_DATA, 8'hA3);
        send_raw(0, {7'h00, 8'h3C, 1'b0}, 9);
        rx0 = 1'b0;
        hold(BIT * 3 / 4);
        rx0 = 1'b1;
        hold(2 * BIT);
        send_8n1(8'hA3);
        hold(BIT);

        // Glitch shorter than half a bit.
        rx0 = 1'b0;
        hold(10);
        check("glitch_busy_high", 32'(b0), 32'h1);
        hold(40);
        rx0 = 1'b1;
        hold(2 * BIT);
        check("glitch_busy_low", 32'(b0), 32'h0);
        check("glitch_no_valid", 32'(v0), 32'h0);

        // Overrun while the consumer stalls.
        rdy0 = 1'b0;
        send_8n1(8'h11);
        check("ovr_first_valid", 32'(v0), 32'h1);
        check("ovr_first_data",  32'(d0), 32'h11);
        expect_ev(0, EV_OVR, 8'h00);
        send_8n1(8'h22);
        check("ovr_data_kept",   32'(d0), 32'h11);
        check("ovr_still_valid", 32'(v0), 32'h1);
        expect_ev(0, EV_DATA, 8'h11);
        rdy0 = 1'b1;
        hold(2);
        check("ovr_valid_cleared", 32'(v0), 32'h0);
        hold(BIT);

        // Reset in the middle of the data bits of 0x81.
        send_raw(0, {11'h000, 4'b0001, 1'b0}, 5);
        rx0   = 1'b0;
        hold(BIT / 2);
        rst_n = 1'b0;
        hold(2);
        check("midrst_rx_data",  32'(d0), 32'h0);
        check("midrst_rx_valid", 32'(v0), 32'h0);
        check("midrst_busy",     32'(b0), 32'h0);
        check("midrst_errs",     32'({fe0, pe0, ov0}), 32'h0);
        rx0   = 1'b1;
        rst_n = 1'b1;
        hold(2 * BIT);
        expect_ev(0, EV_DATA, 8'h81);
        send_8n1(8'h81);
        hold(BIT);

        // Even parity, two stop bits: 0x07 has three ones, so the parity bit must be 1.
        expect_ev(1, EV_PAR, 8'h00);
        send_8e2(8'h07, 1'b0, 1'b1, 1'b1);
        expect_ev(1, EV_DATA, 8'h07);
        send_8e2(8'h07, 1'b1, 1'b1, 1'b1);
        // Bad parity plus a low first stop bit: only the frame error is reported.
        expect_ev(1, EV_FRAME, 8'h00);
        send_8e2(8'h07, 1'b0, 1'b0, 1'b1);
        hold(BIT);
        check("par_busy_low", 32'(b1), 32'h0);

        hold(BIT);
        check("queue0_drained", 32'(q0.size()), 32'h0);
        check("queue1_drained", 32'(q1.size()), 32'h0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
